triangular_wave_analyzer: RTL and testbench

//  Consumer of a sampled triangular waveform: tracks slope direction, detects peaks/troughs,
//  and measures period (in accepted samples), peak, trough and peak-to-trough amplitude.

---
 rtl/triangular_wave_analyzer.sv | 148 ++++++++++++++
 tb/tb_triangular_wave_analyzer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/triangular_wave_analyzer.sv
// Triangular waveform analyzer: slope tracking, peak/trough detection,
// period and amplitude measurement over accepted samples.
module triangular_wave_analyzer #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] peak,
  output logic [DATA_W-1:0] trough,
  output logic [DATA_W-1:0] amplitude,
  output logic [CNT_W-1:0]  period,
  output logic              meas_valid,
  output logic              locked,
  output logic              overflow
);

  typedef enum logic [1:0] {
    IDLE,
    DIR,
    RISE,
    FALL
  } state_e;

  localparam logic [CNT_W-1:0] CMAX = '1;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic [DATA_W-1:0] peak_q, peak_d;
  logic [DATA_W-1:0] trough_q, trough_d;
  logic [DATA_W-1:0] amp_q, amp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic              have_pk_q, have_pk_d;
  logic              mv_q, mv_d;
  logic              locked_q, locked_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic              pk_ev;

  // Saturating increment doubles as the period value reported on a peak.
  assign cnt_inc = (cnt_q == CMAX) ? CMAX : cnt_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    peak_d    = peak_q;
    trough_d  = trough_q;
    amp_d     = amp_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    have_pk_d = have_pk_q;
    mv_d      = 1'b0;
    locked_d  = locked_q;
    ovf_d     = ovf_q;
    pk_ev     = 1'b0;
    if (!ena) begin
      state_d   = IDLE;
      prev_d    = '0;
      peak_d    = '0;
      trough_d  = '0;
      amp_d     = '0;
      cnt_d     = '0;
      period_d  = '0;
      have_pk_d = 1'b0;
      locked_d  = 1'b0;
      ovf_d     = 1'b0;
    end else if (in_valid) begin
      prev_d = in_data;
      cnt_d  = cnt_inc;
      unique case (state_q)
        IDLE: begin
          cnt_d   = '0;
          state_d = DIR;
        end
        DIR: begin
          if (in_data > prev_q) state_d = RISE;
          else if (in_data < prev_q) state_d = FALL;
        end
        RISE: begin
          if (in_data < prev_q) begin
            pk_ev   = 1'b1;
            state_d = FALL;
          end
        end
        FALL: begin
          if (in_data > prev_q) begin
            trough_d = prev_q;
            state_d  = RISE;
          end
        end
        default: state_d = IDLE;
      endcase
      if (pk_ev) begin
        peak_d    = prev_q;
        cnt_d     = '0;
        have_pk_d = 1'b1;
        if (have_pk_q) begin
          period_d = cnt_inc;
          amp_d    = prev_q - trough_q;
          mv_d     = 1'b1;
          locked_d = 1'b1;
          if (cnt_inc == CMAX) ovf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      prev_q    <= '0;
      peak_q    <= '0;
      trough_q  <= '0;
      amp_q     <= '0;
      cnt_q     <= '0;
      period_q  <= '0;
      have_pk_q <= 1'b0;
      mv_q      <= 1'b0;
      locked_q  <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      peak_q    <= peak_d;
      trough_q  <= trough_d;
      amp_q     <= amp_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      have_pk_q <= have_pk_d;
      mv_q      <= mv_d;
      locked_q  <= locked_d;
      ovf_q     <= ovf_d;
    end
  end

  assign peak       = peak_q;
  assign trough     = trough_q;
  assign amplitude  = amp_q;
  assign period     = period_q;
  assign meas_valid = mv_q;
  assign locked     = locked_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_triangular_wave_analyzer.sv
// Directed bench for triangular_wave_analyzer (narrow period counter
// so saturation is reachable quickly).
module tb_triangular_wave_analyzer;

  localparam int DW = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [DW-1:0] peak, trough, amplitude;
  logic [CW-1:0] period;
  logic          meas_valid, locked, overflow;

  int passed = 0;
  int total = 0;
  int nstb = 0;
  int per_q[$];
  int amp_q[$];
  int seq[$];
  int t1[14] = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 1, 2, 3, 4, 3};

  triangular_wave_analyzer #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .peak      (peak),
    .trough    (trough),
    .amplitude (amplitude),
    .period    (period),
    .meas_valid(meas_valid),
    .locked    (locked),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_peak"}, 32'(peak), 0);
    chk({tag, "_trough"}, 32'(trough), 0);
    chk({tag, "_amp"}, 32'(amplitude), 0);
    chk({tag, "_period"}, 32'(period), 0);
    chk({tag, "_flags"}, {29'd0, meas_valid, locked, overflow}, 0);
  endtask

  task automatic step(input bit v, input int d);
    in_valid = v;
    in_data  = d[DW-1:0];
    @(posedge clk);
    #1;
    if (meas_valid === 1'b1) begin
      nstb++;
      per_q.push_back(int'(period));
      amp_q.push_back(int'(amplitude));
    end
  endtask

  task automatic clear(input string tag);
    ena      = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'd7;
    @(posedge clk);
    #1;
    chk_zero(tag);
    ena = 1'b1;
    in_valid = 1'b0;
    nstb = 0;
    per_q.delete();
    amp_q.delete();
  endtask

  function automatic int tri_v(input int i, input int a, input int h);
    int p;
    p = (i / h) % (2 * a);
    return (p <= a) ? p : 2 * a - p;
  endfunction

  initial begin
    #2;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    ena   = 1'b1;

    // basic 0..4 triangle
    for (int i = 0; i < 13; i++) step(1'b1, t1[i]);
    chk("t1_no_early_strobe", nstb, 0);
    chk("t1_first_peak", 32'(peak), 4);
    chk("t1_not_locked", 32'(locked), 0);
    step(1'b1, t1[13]);
    chk("t1_strobe", 32'(meas_valid), 1);
    chk("t1_period", 32'(period), 8);
    chk("t1_peak", 32'(peak), 4);
    chk("t1_trough", 32'(trough), 0);
    chk("t1_amp", 32'(amplitude), 4);
    chk("t1_locked", 32'(locked), 1);
    chk("t1_ovf", 32'(overflow), 0);
    step(1'b0, 0);
    chk("t1_strobe_one_cycle", 32'(meas_valid), 0);
    chk("t1_locked_hold", 32'(locked), 1);

    // A=3, each value held 3 samples
    clear("clr2");
    for (int i = 0; i < 85; i++) step(1'b1, tri_v(i, 3, 3));
    chk("t2_nstrobes", nstb, 4);
    foreach (per_q[k]) chk("t2_period", per_q[k], 18);
    foreach (amp_q[k]) chk("t2_amp", amp_q[k], 3);
    chk("t2_peak", 32'(peak), 3);
    chk("t2_trough", 32'(trough), 0);

    // test 1 with in_valid gaps
    clear("clr3");
    for (int i = 0; i < 14; i++) begin
      step(1'b1, t1[i]);
      if (i == 13) chk("t3_strobe_on_idx13", 32'(meas_valid), 1);
      for (int g = 0; g < (i % 3) + (i % 2); g++) step(1'b0, 55);
    end
    chk("t3_nstrobes", nstb, 1);
    chk("t3_period", per_q[0], 8);
    chk("t3_amp", amp_q[0], 4);
    chk("t3_peak", 32'(peak), 4);
    chk("t3_trough", 32'(trough), 0);

    // constant input
    clear("clr4");
    for (int i = 0; i < 1000; i++) step(1'b1, 100);
    chk("t4_nstrobes", nstb, 0);
    chk_zero("t4");

    // period saturation and sticky overflow
    clear("clr5");
    seq.delete();
    for (int v = 0; v <= 200; v++) seq.push_back(v);
    for (int v = 199; v >= 0; v--) seq.push_back(v);
    for (int v = 1; v <= 200; v++) seq.push_back(v);
    foreach (seq[k]) step(1'b1, seq[k]);
    chk("t5_ovf_before", 32'(overflow), 0);
    chk("t5_nstrobe_before", nstb, 0);
    seq.delete();
    for (int v = 199; v >= 0; v--) seq.push_back(v);
    seq.push_back(1); seq.push_back(2); seq.push_back(3);
    seq.push_back(2); seq.push_back(1); seq.push_back(0);
    seq.push_back(1); seq.push_back(2); seq.push_back(3);
    seq.push_back(2);
    foreach (seq[k]) step(1'b1, seq[k]);
    chk("t5_nstrobes", nstb, 3);
    if (nstb == 3) begin
      chk("t5_period_sat", per_q[0], 255);
      chk("t5_amp0", amp_q[0], 200);
      chk("t5_period1", per_q[1], 203);
      chk("t5_period2", per_q[2], 6);
      chk("t5_amp2", amp_q[2], 3);
    end
    chk("t5_ovf_sticky", 32'(overflow), 1);
    chk("t5_locked", 32'(locked), 1);

    // ena clear mid-stream, then async reset mid-cycle
    clear("clr6");
    for (int i = 0; i < 14; i++) step(1'b1, t1[i]);
    chk("t6_nstrobes", nstb, 1);
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_zero("t6_async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    nstb = 0;
    for (int i = 0; i < 6; i++) step(1'b1, t1[i]);
    chk("t6_peak_after_rst", 32'(peak), 4);
    chk("t6_no_strobe_1st_peak", nstb, 0);
    chk("t6_unlocked", 32'(locked), 0);
    for (int i = 6; i < 14; i++) step(1'b1, t1[i]);
    chk("t6_strobe_2nd_peak", nstb, 1);
    chk("t6_period", 32'(period), 8);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
